video_scanout_timing: RTL and testbench

Raster timing generator and pixel scan-out stage that sits directly downstream of the chunky video mode.
- Drives the mode's video request and 9-bit source pixel X/Y.
- Consumes the mode's 32-bit palette-resolved pixel word.
- Emits registered RGB, hsync, vsync and data-enable to the DAC/HDMI encoder.
- Supplies vblank and frame-start status for the CPU side.
- Source coordinates run ahead of the beam by a fixed lead, so the mode's quad fetch (≥6 clocks per 4 pixels) completes before the pixel is displayed.

---
 rtl/video_pkg.sv | 24 ++
 rtl/video_raster_counter.sv | 44 ++++
 rtl/video_scanout_timing.sv | 110 +++++++++++
 tb/tb_video_scanout_timing.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster timing defaults (640x400@70) and coordinate types for the
// scan-out path.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 400;
  localparam int DEF_V_FP     = 12;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 35;

  typedef logic [9:0] coord_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_raster_counter.sv
// Tick-driven h/v raster position counter. Exposes the position it will hold
// after the current cycle so callers can register outputs in step with it.
module video_raster_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 449,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic   i_clock,
  input  logic   i_reset,
  input  logic   tick,
  output coord_t next_h,
  output coord_t next_v
);

  coord_t h;
  coord_t v;

  always_comb begin
    next_h = h;
    next_v = v;
    if (tick) begin
      if (h == coord_t'(H_TOTAL - 1)) begin
        next_h = '0;
        next_v = (v == coord_t'(V_TOTAL - 1)) ? '0 : v + coord_t'(1);
      end else begin
        next_h = h + coord_t'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      h <= coord_t'(H_INIT);
      v <= coord_t'(V_INIT);
    end else begin
      h <= next_h;
      v <= next_v;
    end
  end

endmodule

// File: rtl/video_scanout_timing.sv
// Raster timing generator and pixel scan-out stage. Fetch coordinates run a
// fixed lead ahead of the beam so the upstream pixel fetch is ready in time.
module video_scanout_timing
  import video_pkg::*;
#(
  parameter int   CLOCK_DIV   = 4,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   SCALE_SHIFT = 1,
  parameter int   LEAD_PIXELS = 4,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_video_request,
  output logic [8:0]  o_video_pos_x,
  output logic [8:0]  o_video_pos_y,
  input  logic [31:0] i_video_rdata,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_data_enable,
  output logic [23:0] o_rgb,
  output logic        o_vblank,
  output logic        o_frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int LEAD    = LEAD_PIXELS << SCALE_SHIFT;
  localparam int DIV_W   = $clog2(CLOCK_DIV);

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             tick;
  coord_t           dh_next, dv_next, fh_next, fv_next;
  logic             de_next, hs_next, vs_next;
  logic             unused_rdata_hi;

  assign tick            = (div == DIV_W'(CLOCK_DIV - 1));
  assign unused_rdata_hi = ^i_video_rdata[31:24];

  always_ff @(posedge i_clock) begin
    if (i_reset || tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  video_raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_INIT(0), .V_INIT(0)
  ) u_display (
    .i_clock(i_clock), .i_reset(i_reset), .tick(tick),
    .next_h(dh_next), .next_v(dv_next)
  );

  // Fetch counter starts LEAD ticks ahead and shares the tick, so the lead is permanent.
  video_raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_INIT(LEAD % H_TOTAL), .V_INIT(LEAD / H_TOTAL)
  ) u_fetch (
    .i_clock(i_clock), .i_reset(i_reset), .tick(tick),
    .next_h(fh_next), .next_v(fv_next)
  );

  assign de_next = (dh_next < H_ACT_C) && (dv_next < V_ACT_C);
  assign hs_next = (dh_next >= HS_START) && (dh_next < HS_END);
  assign vs_next = (dv_next >= VS_START) && (dv_next < VS_END);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_video_request <= 1'b0;
      o_video_pos_x   <= '0;
      o_video_pos_y   <= '0;
      o_hsync         <= ~HSYNC_POL;
      o_vsync         <= ~VSYNC_POL;
      o_data_enable   <= 1'b0;
      o_rgb           <= '0;
      o_vblank        <= 1'b0;
      o_frame_start   <= 1'b0;
    end else begin
      o_video_request <= (fh_next < H_ACT_C) && (fv_next < V_ACT_C);
      o_video_pos_x   <= 9'(fh_next >> SCALE_SHIFT);
      o_video_pos_y   <= 9'(fv_next >> SCALE_SHIFT);
      o_frame_start   <= tick && (dh_next == '0) && (dv_next == '0);
      // Beam-side outputs move only with the pixel tick; pixel data is sampled here too.
      if (tick) begin
        o_data_enable <= de_next;
        o_rgb         <= de_next ? i_video_rdata[23:0] : 24'h0;
        o_hsync       <= hs_next ? HSYNC_POL : ~HSYNC_POL;
        o_vsync       <= vs_next ? VSYNC_POL : ~VSYNC_POL;
        o_vblank      <= (dv_next >= V_ACT_C);
      end
    end
  end

endmodule

// File: tb/tb_video_scanout_timing.sv
// Directed bench: default 640x400 instance for reset/line/mid-line reset,
// plus a tiny-timing instance so a whole frame fits in a short run.
module tb_video_scanout_timing;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        reset_s = 1'b1;
  logic [31:0] rdata   = 32'hFF123456;

  logic       req, hsync, vsync, de, vblank, fs;
  logic [8:0] pos_x, pos_y;
  logic [23:0] rgb;
  logic       req_s, hsync_s, vsync_s, de_s, vblank_s, fs_s;
  logic [8:0] pos_x_s, pos_y_s;
  logic [23:0] rgb_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  video_scanout_timing dut (
    .i_clock(clock), .i_reset(reset), .o_video_request(req),
    .o_video_pos_x(pos_x), .o_video_pos_y(pos_y), .i_video_rdata(rdata),
    .o_hsync(hsync), .o_vsync(vsync), .o_data_enable(de), .o_rgb(rgb),
    .o_vblank(vblank), .o_frame_start(fs)
  );

  video_scanout_timing #(
    .CLOCK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .i_clock(clock), .i_reset(reset_s), .o_video_request(req_s),
    .o_video_pos_x(pos_x_s), .o_video_pos_y(pos_y_s), .i_video_rdata(rdata),
    .o_hsync(hsync_s), .o_vsync(vsync_s), .o_data_enable(de_s), .o_rgb(rgb_s),
    .o_vblank(vblank_s), .o_frame_start(fs_s)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (hsync !== 1'b1)  begin errors++; $display("[TB] FAIL reset_hsync got %0b want 1", hsync); end
    checks++; if (vsync !== 1'b0)  begin errors++; $display("[TB] FAIL reset_vsync got %0b want 0", vsync); end
    checks++; if (de !== 1'b0)     begin errors++; $display("[TB] FAIL reset_de got %0b want 0", de); end
    checks++; if (rgb !== 24'h0)   begin errors++; $display("[TB] FAIL reset_rgb got %h want 0", rgb); end
    checks++; if (req !== 1'b0)    begin errors++; $display("[TB] FAIL reset_req got %0b want 0", req); end
    checks++; if (pos_x !== 9'd0)  begin errors++; $display("[TB] FAIL reset_pos_x got %0d want 0", pos_x); end
    checks++; if (pos_y !== 9'd0)  begin errors++; $display("[TB] FAIL reset_pos_y got %0d want 0", pos_y); end
    checks++; if (vblank !== 1'b0) begin errors++; $display("[TB] FAIL reset_vblank got %0b want 0", vblank); end
    checks++; if (fs !== 1'b0)     begin errors++; $display("[TB] FAIL reset_frame_start got %0b want 0", fs); end
  endtask

  task automatic test_first_tick();
    reset = 1'b0;
    repeat (3) begin step(); cyc++; end
    checks++; if (de !== 1'b0)    begin errors++; $display("[TB] FAIL pre_tick_de got %0b want 0", de); end
    checks++; if (req !== 1'b1)   begin errors++; $display("[TB] FAIL pre_tick_req got %0b want 1", req); end
    checks++; if (pos_x !== 9'd4) begin errors++; $display("[TB] FAIL pre_tick_pos_x got %0d want 4", pos_x); end
    step(); cyc++;
    checks++; if (de !== 1'b1)         begin errors++; $display("[TB] FAIL tick_de got %0b want 1", de); end
    checks++; if (rgb !== 24'h123456)  begin errors++; $display("[TB] FAIL tick_rgb got %h want 123456", rgb); end
    checks++; if (pos_x !== 9'd4)      begin errors++; $display("[TB] FAIL tick_pos_x got %0d want 4", pos_x); end
    checks++; if (pos_y !== 9'd0)      begin errors++; $display("[TB] FAIL tick_pos_y got %0d want 0", pos_y); end
    checks++; if (req !== 1'b1)        begin errors++; $display("[TB] FAIL tick_req got %0b want 1", req); end
    checks++; if (hsync !== 1'b1)      begin errors++; $display("[TB] FAIL tick_hsync got %0b want 1", hsync); end
    checks++; if (fs !== 1'b0)         begin errors++; $display("[TB] FAIL tick_frame_start got %0b want 0", fs); end
  endtask

  // Window of clocks 4..3203 covers display h=1..799 and h=0 of the next line, 4 clocks each.
  task automatic test_line();
    int hs_low = 0, de_hi = 0, first_hs = -1;
    int bad_de = 0, bad_hs = 0, bad_vs = 0, bad_rgb = 0, bad_req = 0, bad_pos = 0;
    int t, dh, dv, fh, fv;
    logic de_m, hs_m, req_m;
    for (int k = 4; k <= 3203; k++) begin
      if (k > 4) begin step(); cyc++; end
      t = k / 4; dh = t % 800; dv = t / 800;
      fh = (t + 8) % 800; fv = (t + 8) / 800;
      de_m  = (dh < 640) && (dv < 400);
      hs_m  = !((dh >= 656) && (dh < 752));
      req_m = (fh < 640) && (fv < 400);
      if (!hsync) begin hs_low++; if (first_hs < 0) first_hs = k; end
      if (de) de_hi++;
      if (de !== de_m) bad_de++;
      if (hsync !== hs_m) bad_hs++;
      if (vsync !== 1'b0 || vblank !== 1'b0) bad_vs++;
      if (rgb !== (de_m ? 24'h123456 : 24'h0)) bad_rgb++;
      if (req !== req_m) bad_req++;
      if (pos_x !== 9'(fh >> 1) || pos_y !== 9'(fv >> 1)) bad_pos++;
      if (k == 2528) begin
        checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL line_end_req got %0b want 0", req); end
      end
      if (k == 3168) begin
        checks++; if (req !== 1'b1)   begin errors++; $display("[TB] FAIL wrap_req got %0b want 1", req); end
        checks++; if (pos_x !== 9'd0) begin errors++; $display("[TB] FAIL wrap_pos_x got %0d want 0", pos_x); end
        checks++; if (pos_y !== 9'd0) begin errors++; $display("[TB] FAIL wrap_pos_y got %0d want 0", pos_y); end
      end
    end
    checks++; if (hs_low !== 384)    begin errors++; $display("[TB] FAIL line_hsync_len got %0d want 384", hs_low); end
    checks++; if (first_hs !== 2624) begin errors++; $display("[TB] FAIL line_hsync_start got clk %0d want 2624", first_hs); end
    checks++; if (de_hi !== 2560)    begin errors++; $display("[TB] FAIL line_de_len got %0d want 2560", de_hi); end
    checks++; if (bad_de !== 0)  begin errors++; $display("[TB] FAIL line_de_cycles got %0d bad want 0", bad_de); end
    checks++; if (bad_hs !== 0)  begin errors++; $display("[TB] FAIL line_hsync_cycles got %0d bad want 0", bad_hs); end
    checks++; if (bad_vs !== 0)  begin errors++; $display("[TB] FAIL line_vsync_vblank got %0d bad want 0", bad_vs); end
    checks++; if (bad_rgb !== 0) begin errors++; $display("[TB] FAIL line_rgb got %0d bad want 0", bad_rgb); end
    checks++; if (bad_req !== 0) begin errors++; $display("[TB] FAIL line_req got %0d bad want 0", bad_req); end
    checks++; if (bad_pos !== 0) begin errors++; $display("[TB] FAIL line_pos got %0d bad want 0", bad_pos); end
  endtask

  task automatic test_mid_line_reset();
    int fs_seen = 0;
    while (cyc < 4400) begin step(); cyc++; end
    checks++; if (de !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_de got %0b want 1", de); end
    reset = 1'b1;
    step();
    checks++; if (de !== 1'b0)     begin errors++; $display("[TB] FAIL mid_reset_de got %0b want 0", de); end
    checks++; if (rgb !== 24'h0)   begin errors++; $display("[TB] FAIL mid_reset_rgb got %h want 0", rgb); end
    checks++; if (req !== 1'b0)    begin errors++; $display("[TB] FAIL mid_reset_req got %0b want 0", req); end
    checks++; if (pos_x !== 9'd0)  begin errors++; $display("[TB] FAIL mid_reset_pos_x got %0d want 0", pos_x); end
    checks++; if (pos_y !== 9'd0)  begin errors++; $display("[TB] FAIL mid_reset_pos_y got %0d want 0", pos_y); end
    checks++; if (fs !== 1'b0)     begin errors++; $display("[TB] FAIL mid_reset_frame_start got %0b want 0", fs); end
    checks++; if (hsync !== 1'b1)  begin errors++; $display("[TB] FAIL mid_reset_hsync got %0b want 1", hsync); end
    reset = 1'b0;
    cyc = 0;
    repeat (4) begin step(); cyc++; if (fs) fs_seen++; end
    checks++; if (de !== 1'b1)    begin errors++; $display("[TB] FAIL restart_de got %0b want 1", de); end
    checks++; if (pos_x !== 9'd4) begin errors++; $display("[TB] FAIL restart_pos_x got %0d want 4", pos_x); end
    checks++; if (fs_seen !== 0)  begin errors++; $display("[TB] FAIL restart_frame_start got %0d pulses want 0", fs_seen); end
    // Reset inside the hsync pulse must end it immediately.
    while (cyc < 2800) begin step(); cyc++; end
    checks++; if (hsync !== 1'b0) begin errors++; $display("[TB] FAIL in_sync_hsync got %0b want 0", hsync); end
    reset = 1'b1;
    step();
    checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL sync_reset_hsync got %0b want 1", hsync); end
    reset = 1'b0;
    step();
    checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL sync_resume_hsync got %0b want 1", hsync); end
    checks++; if (de !== 1'b0)    begin errors++; $display("[TB] FAIL sync_resume_de got %0b want 0", de); end
  endtask

  // Tiny timing: H_TOTAL 16, V_TOTAL 10, 2 clocks per tick, lead 8 ticks.
  task automatic test_frame();
    int fs_cnt = 0, fs_at = -1, vs_cnt = 0, first_vs = -1, vb_cnt = 0, de_cnt = 0, hs_low = 0;
    int bad_disp = 0, bad_fetch = 0;
    int t, p, dh, dv, q, fh, fv;
    logic run, de_m, hs_m, vs_m, vb_m, fs_m, req_m;
    reset_s = 1'b0;
    for (int k = 1; k <= 321; k++) begin
      step();
      run = (k >= 2);
      t = k / 2; p = t % 160; dh = p % 16; dv = p / 16;
      q = (t + 8) % 160; fh = q % 16; fv = q / 16;
      de_m  = run && (dh < 8) && (dv < 6);
      hs_m  = !(run && (dh >= 10) && (dh < 13));
      vs_m  = run && (dv >= 7) && (dv < 9);
      vb_m  = run && (dv >= 6);
      fs_m  = run && (k % 2 == 0) && (p == 0);
      req_m = (fh < 8) && (fv < 6);
      if (fs_s) begin fs_cnt++; fs_at = k; end
      if (vsync_s) begin vs_cnt++; if (first_vs < 0) first_vs = k; end
      if (vblank_s) vb_cnt++;
      if (de_s) de_cnt++;
      if (!hsync_s) hs_low++;
      if (de_s !== de_m || hsync_s !== hs_m || vsync_s !== vs_m || vblank_s !== vb_m || fs_s !== fs_m
          || rgb_s !== (de_m ? 24'h123456 : 24'h0)) bad_disp++;
      if (req_s !== req_m || pos_x_s !== 9'(fh >> 1) || pos_y_s !== 9'(fv >> 1)) bad_fetch++;
    end
    checks++; if (fs_cnt !== 1)    begin errors++; $display("[TB] FAIL frame_start_count got %0d want 1", fs_cnt); end
    checks++; if (fs_at !== 320)   begin errors++; $display("[TB] FAIL frame_start_clock got %0d want 320", fs_at); end
    checks++; if (vs_cnt !== 64)   begin errors++; $display("[TB] FAIL frame_vsync_len got %0d want 64", vs_cnt); end
    checks++; if (first_vs !== 224) begin errors++; $display("[TB] FAIL frame_vsync_start got %0d want 224", first_vs); end
    checks++; if (vb_cnt !== 128)  begin errors++; $display("[TB] FAIL frame_vblank_len got %0d want 128", vb_cnt); end
    checks++; if (de_cnt !== 96)   begin errors++; $display("[TB] FAIL frame_de_len got %0d want 96", de_cnt); end
    checks++; if (hs_low !== 60)   begin errors++; $display("[TB] FAIL frame_hsync_len got %0d want 60", hs_low); end
    checks++; if (bad_disp !== 0)  begin errors++; $display("[TB] FAIL frame_display_cycles got %0d bad want 0", bad_disp); end
    checks++; if (bad_fetch !== 0) begin errors++; $display("[TB] FAIL frame_fetch_cycles got %0d bad want 0", bad_fetch); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_first_tick();
    test_line();
    test_mid_line_reset();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
